jk_cmd_arbiter: RTL and testbench
=================================

// Module: jk_cmd_arbiter
// PURPOSE
//   Shares one bank of WIDTH external JK flip-flops (jk_ff instances) between NREQ requesters.
//   Each requester posts a masked command: hold, reset, set or toggle. A round-robin arbiter
//   grants one command at a time. The controller drives the bank's J/K lines for exactly one
//   clock, reads back Q, checks it against the JK truth table and reports completion.
// PARAMETERS
//   NREQ   4   number of requesters (>=2)
//   WIDTH  8   number of JK flip-flops in the controlled bank
// PORTS
//   clk         in   1           rising-edge clock, shared with the JK bank
//   rst_n       in   1           asynchronous active-low reset
//   req_valid   in   NREQ        requester i has a command pending
//   req_ready   out  NREQ        one-hot grant; handshake when valid[i]&ready[i] at clk edge
//   req_op      in   2*NREQ      op of req i at [2i+1:2i]; {J,K}: 00 hold,01 reset,10 set,11 toggle
//   req_mask    in   WIDTH*NREQ  bit mask of req i at [WIDTH*i +: WIDTH]; 1 = bit affected
//   jk_j        out  WIDTH       J inputs to bank (registered)
//   jk_k        out  WIDTH       K inputs to bank (registered)
//   jk_q        in   WIDTH       Q outputs of bank
//   busy        out  1           command in flight (state != IDLE)
//   done_valid  out  1           one-cycle completion pulse
//   done_id     out  log2(NREQ)  requester index of completed command
//   done_q      out  WIDTH       bank Q captured after the command
//   done_err    out  1           done_q != expected Q (valid with done_valid)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, rr_ptr=0, jk_j=jk_k=0, busy=0, done_valid=0,
//     done_id=0, done_q=0, done_err=0. req_ready=0 while rst_n=0.
//   FSM IDLE -> ISSUE -> CAPTURE -> IDLE. Throughput: 1 command per 3 clocks.
//   IDLE: req_ready is combinational, one-hot, asserted only in IDLE:
//     - Grant goes to the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap mod NREQ.
//     - req_ready=0 if no request is valid.
//   On the handshake edge:
//     - latch id, op, mask; sample q_before=jk_q;
//     - load jk_j={WIDTH{op[1]}}&mask and jk_k={WIDTH{op[0]}}&mask;
//     - rr_ptr=(id+1) mod NREQ; next state ISSUE.
//   ISSUE (1 clk): J/K held stable and the bank updates on the edge ending ISSUE.
//     - On that edge: jk_j=jk_k=0; expected Q computed per bit:
//       mask=0 -> q_before; 00 -> q_before; 01 -> 0; 10 -> 1; 11 -> ~q_before.
//     - Next state CAPTURE.
//   CAPTURE (1 clk): on its ending edge register done_q=jk_q, done_id=id,
//     done_err=(jk_q!=expected), done_valid=1; next state IDLE.
//   done_valid is high for exactly the first IDLE cycle after CAPTURE.
//     - A new grant may handshake in that same cycle (done and accept coexist).
//   jk_j/jk_k are 0 in IDLE and CAPTURE, so the bank always holds outside ISSUE.
//   Requester must hold valid/op/mask stable until its ready; payload is ignored after handshake.
//   A valid dropped before grant is simply not served; no error.
//   Mask=0 or op=00: full sequence still runs, done_q=q_before, done_err=0 if bank is correct.
//   busy=1 in ISSUE and CAPTURE.
//   Async reset mid-command:
//     - J/K forced to 0 immediately, so no partial toggle is issued.
//     - The command is dropped and no done_valid is produced.
//     - rr_ptr returns to 0.
// TESTING (NREQ=4, WIDTH=8, bank of jk_ff on same clk)
//   1 Reset: rst_n=0 for 2 clks -> jk_j=jk_k=0, req_ready=0, done_valid=0, busy=0.
//   2 Single op: bank Q=00; req0 set mask 8'h0F.
//     - Ready same cycle; J=0F,K=00 for 1 clk.
//     - done_valid 3 clks after handshake, done_q=0F, done_err=0.
//   3 Toggle/reset: from Q=0F, req1 toggle mask FF -> done_q=F0.
//     - Then req2 reset mask 30 -> done_q=C0, done_err=0.
//   4 Round robin: all 4 valid continuously, rr_ptr=0.
//     - Grants in order 0,1,2,3,0, one every 3 clks; each done_id matches its grant.
//   5 Error check: force bank Q bit0 stuck at 0; req3 set mask 01 -> done_q[0]=0, done_err=1.
//   6 Reset during ISSUE: assert rst_n=0 mid-ISSUE.
//     - J/K drop to 0 at once; bank Q unchanged; no done_valid.
//     - After release, req0 is granted first.

Source files
------------

// File: rtl/jk_cmd_arbiter_if.sv
// Command/bank bundle between requesters, the JK bank and jk_cmd_arbiter.
// The master side is the environment (requesters and the bank); the slave side is the arbiter.
interface jk_cmd_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_mask;
    logic [WIDTH-1:0]      jk_j;
    logic [WIDTH-1:0]      jk_k;
    logic [WIDTH-1:0]      jk_q;
    logic                  busy;
    logic                  done_valid;
    logic [IDW-1:0]        done_id;
    logic [WIDTH-1:0]      done_q;
    logic                  done_err;

    modport master (
        output req_valid, req_op, req_mask, jk_q,
        input  req_ready, jk_j, jk_k, busy, done_valid, done_id, done_q, done_err
    );

    modport slave (
        input  req_valid, req_op, req_mask, jk_q,
        output req_ready, jk_j, jk_k, busy, done_valid, done_id, done_q, done_err
    );
endinterface

// File: rtl/jk_cmd_arbiter.sv
// Round-robin arbiter that applies one masked JK command at a time to a shared
// bank of JK flip-flops, then reads the bank back and checks it against the truth table.
module jk_cmd_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    jk_cmd_arbiter_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   next_ptr;
    logic [IDW-1:0]   grant_id;
    logic             grant_found;
    logic [IDW:0]     cand;
    logic [NREQ-1:0]  ready_oh;
    logic             handshake;

    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_mask;

    logic [IDW-1:0]   cmd_id;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [WIDTH-1:0] q_before;
    logic [WIDTH-1:0] op_value;
    logic [WIDTH-1:0] exp_q_next;
    logic [WIDTH-1:0] exp_q;

    logic [WIDTH-1:0] jk_j_r;
    logic [WIDTH-1:0] jk_k_r;
    logic             done_valid_r;
    logic [IDW-1:0]   done_id_r;
    logic [WIDTH-1:0] done_q_r;
    logic             done_err_r;

    // Search starts at rr_ptr and wraps modulo NREQ, so NREQ need not be a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        ready_oh = '0;
        if (rst_n && (state == IDLE) && grant_found) begin
            ready_oh[grant_id] = 1'b1;
        end
    end

    assign handshake = |ready_oh;
    assign next_ptr  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        sel_op   = '0;
        sel_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_op   = bus.req_op[2*i +: 2];
                sel_mask = bus.req_mask[WIDTH*i +: WIDTH];
            end
        end
    end

    // Unmasked bits keep q_before; masked bits take the JK result for the latched op.
    always_comb begin
        op_value = q_before;
        case (cmd_op)
            2'b00:   op_value = q_before;
            2'b01:   op_value = '0;
            2'b10:   op_value = '1;
            2'b11:   op_value = ~q_before;
            default: op_value = q_before;
        endcase
        exp_q_next = (cmd_mask & op_value) | (~cmd_mask & q_before);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // J/K are only non-zero during ISSUE, so reset also cancels any partial command on the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            cmd_id       <= '0;
            cmd_op       <= '0;
            cmd_mask     <= '0;
            q_before     <= '0;
            exp_q        <= '0;
            jk_j_r       <= '0;
            jk_k_r       <= '0;
            done_valid_r <= 1'b0;
            done_id_r    <= '0;
            done_q_r     <= '0;
            done_err_r   <= 1'b0;
        end else begin
            done_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        cmd_id   <= grant_id;
                        cmd_op   <= sel_op;
                        cmd_mask <= sel_mask;
                        q_before <= bus.jk_q;
                        jk_j_r   <= {WIDTH{sel_op[1]}} & sel_mask;
                        jk_k_r   <= {WIDTH{sel_op[0]}} & sel_mask;
                        rr_ptr   <= next_ptr;
                    end
                end
                ISSUE: begin
                    jk_j_r <= '0;
                    jk_k_r <= '0;
                    exp_q  <= exp_q_next;
                end
                CAPTURE: begin
                    done_valid_r <= 1'b1;
                    done_id_r    <= cmd_id;
                    done_q_r     <= bus.jk_q;
                    done_err_r   <= (bus.jk_q != exp_q);
                end
                default: begin
                    jk_j_r <= '0;
                    jk_k_r <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_oh;
    assign bus.jk_j       = jk_j_r;
    assign bus.jk_k       = jk_k_r;
    assign bus.busy       = (state != IDLE);
    assign bus.done_valid = done_valid_r;
    assign bus.done_id    = done_id_r;
    assign bus.done_q     = done_q_r;
    assign bus.done_err   = done_err_r;
endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// Bench for jk_cmd_arbiter: a behavioural JK bank on the same clock, directed command
// vectors, multi-cycle corner sequences and a randomized run against a reference model.
module tb_jk_cmd_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    typedef struct {
        int               id;
        logic [1:0]       op;
        logic [WIDTH-1:0] mask;
        bit               load;
        logic [WIDTH-1:0] load_val;
        logic [WIDTH-1:0] stuck;
        logic [WIDTH-1:0] exp_q;
        bit               exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    jk_cmd_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();

    jk_cmd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] bank_raw;
    logic [WIDTH-1:0] stuck_zero = '0;
    logic [WIDTH-1:0] load_val = '0;
    logic             load_en = 1'b0;

    // The bank has no reset: it only changes through J/K or a bench load.
    always @(posedge clk) begin
        if (load_en) begin
            bank_raw <= load_val;
        end else begin
            for (int b = 0; b < WIDTH; b++) begin
                case ({bus.jk_j[b], bus.jk_k[b]})
                    2'b01:   bank_raw[b] <= 1'b0;
                    2'b10:   bank_raw[b] <= 1'b1;
                    2'b11:   bank_raw[b] <= ~bank_raw[b];
                    default: ;
                endcase
            end
        end
    end

    assign bus.jk_q = bank_raw & ~stuck_zero;

    function automatic logic [WIDTH-1:0] apply_jk(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] mask,
                                                  input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] r;
        r = q;
        for (int b = 0; b < WIDTH; b++) begin
            if (mask[b]) begin
                if (op == 2'b01)      r[b] = 1'b0;
                else if (op == 2'b10) r[b] = 1'b1;
                else if (op == 2'b11) r[b] = ~q[b];
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [WIDTH-1:0] mask);
        bus.req_valid[id]             = 1'b1;
        bus.req_op[2*id +: 2]         = op;
        bus.req_mask[WIDTH*id +: WIDTH] = mask;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        bus.req_valid = '1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_ready", bus.req_ready, 0);
            checkOutput("rst_jk_j", bus.jk_j, 0);
            checkOutput("rst_jk_k", bus.jk_k, 0);
            checkOutput("rst_done_valid", bus.done_valid, 0);
            checkOutput("rst_busy", bus.busy, 0);
            next_cycle();
        end
        rst_n = 1'b1;
        bus.req_valid = '0;
    endtask

    // One isolated command: handshake, ISSUE, CAPTURE, then the done cycle.
    task automatic applyStimulus(input vec_t v);
        if (v.load) begin
            load_val = v.load_val;
            load_en  = 1'b1;
            next_cycle();
            load_en  = 1'b0;
        end
        stuck_zero    = v.stuck;
        bus.req_valid = '0;
        set_req(v.id, v.op, v.mask);
        @(negedge clk);
        checkOutput("vec_ready", bus.req_ready, 32'(1) << v.id);
        checkOutput("vec_busy_idle", bus.busy, 0);
        next_cycle();
        bus.req_valid = '0;
        @(negedge clk);
        checkOutput("vec_issue_j", bus.jk_j, {WIDTH{v.op[1]}} & v.mask);
        checkOutput("vec_issue_k", bus.jk_k, {WIDTH{v.op[0]}} & v.mask);
        checkOutput("vec_issue_busy", bus.busy, 1);
        checkOutput("vec_issue_ready", bus.req_ready, 0);
        next_cycle();
        @(negedge clk);
        checkOutput("vec_capture_j", bus.jk_j, 0);
        checkOutput("vec_capture_k", bus.jk_k, 0);
        checkOutput("vec_capture_done", bus.done_valid, 0);
        next_cycle();
        @(negedge clk);
        checkOutput("vec_done_valid", bus.done_valid, 1);
        checkOutput("vec_done_id", bus.done_id, v.id);
        checkOutput("vec_done_q", bus.done_q, v.exp_q);
        checkOutput("vec_done_err", bus.done_err, v.exp_err);
        checkOutput("vec_done_busy", bus.busy, 0);
        next_cycle();
        @(negedge clk);
        checkOutput("vec_done_pulse", bus.done_valid, 0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, expected run to finish");
        $fatal(1, "[TB] timeout");
    end

    vec_t vecs[7];

    bit               pend [NREQ];
    logic [1:0]       p_op [NREQ];
    logic [WIDTH-1:0] p_mask [NREQ];
    int               m_ptr, m_phase, m_id, g;
    logic [1:0]       m_op;
    logic [WIDTH-1:0] m_mask, m_qb, e_j, e_k, e_q;
    bit               e_dv;
    int               e_id;

    initial begin
        vecs[0] = '{0, 2'b10, 8'h0F, 1'b1, 8'h00, 8'h00, 8'h0F, 1'b0};
        vecs[1] = '{1, 2'b11, 8'hFF, 1'b0, 8'h00, 8'h00, 8'hF0, 1'b0};
        vecs[2] = '{2, 2'b01, 8'h30, 1'b0, 8'h00, 8'h00, 8'hC0, 1'b0};
        vecs[3] = '{3, 2'b00, 8'hFF, 1'b0, 8'h00, 8'h00, 8'hC0, 1'b0};
        vecs[4] = '{0, 2'b11, 8'h00, 1'b0, 8'h00, 8'h00, 8'hC0, 1'b0};
        vecs[5] = '{3, 2'b10, 8'h01, 1'b1, 8'h00, 8'h01, 8'h00, 1'b1};
        vecs[6] = '{1, 2'b11, 8'hF0, 1'b1, 8'hAA, 8'h00, 8'h5A, 1'b0};

        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_mask  = '0;
        load_val      = '0;
        load_en       = 1'b1;
        doReset();
        load_en       = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end
        stuck_zero = '0;

        $display("[TB] round-robin sequence");
        doReset();
        bus.req_op    = '0;
        bus.req_mask  = 32'hA5C3_0F11;
        bus.req_valid = '1;
        for (int gi = 0; gi < 5; gi++) begin
            @(negedge clk);
            checkOutput("rr_ready", bus.req_ready, 32'(1) << (gi % NREQ));
            if (gi > 0) begin
                checkOutput("rr_done_valid", bus.done_valid, 1);
                checkOutput("rr_done_id", bus.done_id, (gi - 1) % NREQ);
            end
            next_cycle();
            if (gi == 4) bus.req_valid = '0;
            next_cycle();
            next_cycle();
        end
        @(negedge clk);
        checkOutput("rr_last_done_valid", bus.done_valid, 1);
        checkOutput("rr_last_done_id", bus.done_id, 0);
        next_cycle();

        $display("[TB] reset during ISSUE");
        load_val = 8'h0F;
        load_en  = 1'b1;
        next_cycle();
        load_en  = 1'b0;
        set_req(2, 2'b11, 8'hFF);
        @(negedge clk);
        checkOutput("ri_ready", bus.req_ready, 32'h4);
        next_cycle();
        bus.req_valid = '0;
        checkOutput("ri_issue_j", bus.jk_j, 8'hFF);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("ri_async_j", bus.jk_j, 0);
        checkOutput("ri_async_k", bus.jk_k, 0);
        checkOutput("ri_async_busy", bus.busy, 0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("ri_no_done", bus.done_valid, 0);
            checkOutput("ri_bank_hold", bus.jk_q, 8'h0F);
            next_cycle();
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ri_post_no_done", bus.done_valid, 0);
        bus.req_op    = '0;
        bus.req_valid = '1;
        #1;
        checkOutput("ri_first_grant", bus.req_ready, 32'h1);
        next_cycle();
        bus.req_valid = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checkOutput("ri_done_id", bus.done_id, 0);
        checkOutput("ri_done_q", bus.done_q, 8'h0F);
        next_cycle();

        $display("[TB] randomized run");
        doReset();
        load_val = WIDTH'($urandom_range(255));
        load_en  = 1'b1;
        next_cycle();
        load_en  = 1'b0;
        m_ptr = 0; m_phase = 0; m_id = 0; e_dv = 1'b0; e_id = 0;
        e_j = '0; e_k = '0; e_q = '0; m_op = '0; m_mask = '0; m_qb = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; p_op[i] = '0; p_mask[i] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(3) == 0) begin
                    pend[i]   = 1'b1;
                    p_op[i]   = 2'($urandom_range(3));
                    p_mask[i] = WIDTH'($urandom_range(255));
                end else if (pend[i] && $urandom_range(15) == 0) begin
                    pend[i] = 1'b0;
                end
                bus.req_valid[i]              = pend[i];
                bus.req_op[2*i +: 2]          = p_op[i];
                bus.req_mask[WIDTH*i +: WIDTH] = p_mask[i];
            end
            @(negedge clk);
            g = -1;
            if (m_phase == 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && pend[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
            end
            checkOutput("rand_ready", bus.req_ready, (g >= 0) ? (32'(1) << g) : 32'(0));
            checkOutput("rand_busy", bus.busy, (m_phase != 0) ? 1 : 0);
            checkOutput("rand_jk_j", bus.jk_j, e_j);
            checkOutput("rand_jk_k", bus.jk_k, e_k);
            checkOutput("rand_done_valid", bus.done_valid, e_dv);
            if (e_dv) begin
                checkOutput("rand_done_id", bus.done_id, e_id);
                checkOutput("rand_done_q", bus.done_q, e_q);
                checkOutput("rand_done_err", bus.done_err, 0);
            end
            e_dv = (m_phase == 2);
            if (m_phase == 2) begin
                e_id    = m_id;
                e_q     = apply_jk(m_op, m_mask, m_qb);
                m_phase = 0;
            end else if (m_phase == 1) begin
                e_j     = '0;
                e_k     = '0;
                m_phase = 2;
            end else if (g >= 0) begin
                m_id    = g;
                m_op    = p_op[g];
                m_mask  = p_mask[g];
                m_qb    = bus.jk_q;
                e_j     = {WIDTH{m_op[1]}} & m_mask;
                e_k     = {WIDTH{m_op[0]}} & m_mask;
                m_ptr   = (g + 1) % NREQ;
                pend[g] = 1'b0;
                m_phase = 1;
            end
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
